// File: rtl/mem_arbiter_pkg.sv
// Shared widths and arbiter state encoding for the memory-port arbiter slice.
package mem_arbiter_pkg;
  localparam int MEM_AW = 32;
  localparam int MEM_DW = 32;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT_I = 2'd1,
    ARB_GRANT_D = 2'd2
  } arb_state_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// Bundles the I-cache, D-cache and memory sides of the shared memory port.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
();
  logic [MEM_AW-1:0] i_mem_addr;
  logic              i_mem_read;
  logic [MEM_DW-1:0] i_mem_rdata;
  logic              i_mem_ready;
  logic [MEM_AW-1:0] d_mem_addr;
  logic              d_mem_read;
  logic              d_mem_write;
  logic [MEM_DW-1:0] d_mem_wdata;
  logic [MEM_DW-1:0] d_mem_rdata;
  logic              d_mem_ready;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_read;
  logic              mem_write;
  logic [MEM_DW-1:0] mem_wdata;
  logic [MEM_DW-1:0] mem_rdata;
  logic              mem_ready;

  // Arbiter view.
  modport slave (
    input  i_mem_addr, i_mem_read, d_mem_addr, d_mem_read, d_mem_write, d_mem_wdata,
           mem_rdata, mem_ready,
    output i_mem_rdata, i_mem_ready, d_mem_rdata, d_mem_ready,
           mem_addr, mem_read, mem_write, mem_wdata
  );

  // Caches-plus-memory view.
  modport master (
    output i_mem_addr, i_mem_read, d_mem_addr, d_mem_read, d_mem_write, d_mem_wdata,
           mem_rdata, mem_ready,
    input  i_mem_rdata, i_mem_ready, d_mem_rdata, d_mem_ready,
           mem_addr, mem_read, mem_write, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter_sat_counter.sv
// Saturating up-counter: increments on inc, holds once it reaches all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         proc_reset,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      cnt_reg <= '0;
    end else if (inc && (cnt_reg != '1)) begin
      cnt_reg <= cnt_reg + {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign cnt = cnt_reg;
endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between I-cache and D-cache,
// with per-port saturating completion counters and a sticky D-port protocol flag.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             proc_reset,
  mem_arbiter_if.slave     bus,
  output logic [CNT_W-1:0] i_txn_cnt,
  output logic [CNT_W-1:0] d_txn_cnt,
  output logic             proto_err
);
  arb_state_t        state_reg, state_next;
  logic              last_grant_reg, last_grant_next;
  logic              proto_err_reg;
  logic              req_i, req_d;
  logic [MEM_AW-1:0] mem_addr_next;
  logic [MEM_DW-1:0] mem_wdata_next;
  logic              mem_read_next, mem_write_next;
  logic              i_ready_next, d_ready_next;
  logic [1:0]        txn_inc;
  logic [CNT_W-1:0]  txn_cnt [2];

  assign req_i = bus.i_mem_read;
  assign req_d = bus.d_mem_read | bus.d_mem_write;

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_reg      <= ARB_IDLE;
      last_grant_reg <= 1'b0;
      proto_err_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      proto_err_reg  <= proto_err_reg | (bus.d_mem_read & bus.d_mem_write);
    end
  end

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    mem_addr_next   = '0;
    mem_wdata_next  = '0;
    mem_read_next   = 1'b0;
    mem_write_next  = 1'b0;
    i_ready_next    = 1'b0;
    d_ready_next    = 1'b0;
    case (state_reg)
      ARB_IDLE: begin
        // On contention the port that did not win last time goes next.
        if (req_i && (!req_d || last_grant_reg)) begin
          state_next      = ARB_GRANT_I;
          last_grant_next = 1'b0;
        end else if (req_d) begin
          state_next      = ARB_GRANT_D;
          last_grant_next = 1'b1;
        end
      end
      ARB_GRANT_I: begin
        mem_addr_next = bus.i_mem_addr;
        mem_read_next = bus.i_mem_read;
        if (bus.mem_ready) begin
          i_ready_next = 1'b1;
          state_next   = ARB_IDLE;
        end else if (!req_i) begin
          state_next = ARB_IDLE;
        end
      end
      ARB_GRANT_D: begin
        // A simultaneous read+write from the D-cache is serviced as a write.
        mem_addr_next  = bus.d_mem_addr;
        mem_wdata_next = bus.d_mem_wdata;
        mem_write_next = bus.d_mem_write;
        mem_read_next  = bus.d_mem_read & ~bus.d_mem_write;
        if (bus.mem_ready) begin
          d_ready_next = 1'b1;
          state_next   = ARB_IDLE;
        end else if (!req_d) begin
          state_next = ARB_IDLE;
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  assign bus.mem_addr    = mem_addr_next;
  assign bus.mem_wdata   = mem_wdata_next;
  assign bus.mem_read    = mem_read_next;
  assign bus.mem_write   = mem_write_next;
  assign bus.i_mem_ready = i_ready_next;
  assign bus.d_mem_ready = d_ready_next;
  assign bus.i_mem_rdata = bus.mem_rdata;
  assign bus.d_mem_rdata = bus.mem_rdata;
  assign proto_err       = proto_err_reg;

  assign txn_inc = {d_ready_next, i_ready_next};

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_txn_cnt
    sat_counter #(.W(CNT_W)) u_cnt (
      .clk        (clk),
      .proc_reset (proc_reset),
      .inc        (txn_inc[gi]),
      .cnt        (txn_cnt[gi])
    );
  end

  assign i_txn_cnt = txn_cnt[0];
  assign d_txn_cnt = txn_cnt[1];
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; counters narrowed to 2 bits so saturation is reachable.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             proc_reset;
  logic [CNT_W-1:0] i_txn_cnt, d_txn_cnt;
  logic             proto_err;
  int               total = 0;
  int               bad = 0;

  mem_arbiter_if bus ();

  mem_arbiter #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .bus        (bus),
    .i_txn_cnt  (i_txn_cnt),
    .d_txn_cnt  (d_txn_cnt),
    .proto_err  (proto_err)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.i_mem_addr  = '0;
    bus.i_mem_read  = 1'b0;
    bus.d_mem_addr  = '0;
    bus.d_mem_read  = 1'b0;
    bus.d_mem_write = 1'b0;
    bus.d_mem_wdata = '0;
    bus.mem_rdata   = '0;
    bus.mem_ready   = 1'b0;
  endtask

  task automatic do_reset();
    proc_reset = 1'b1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    proc_reset = 1'b0;
  endtask

  task automatic test_reset();
    proc_reset = 1'b1;
    clear_inputs();
    bus.i_mem_read = 1'b1;
    bus.d_mem_write = 1'b1;
    bus.d_mem_addr = 32'h55;
    bus.d_mem_wdata = 32'h77;
    bus.mem_ready = 1'b1;
    @(negedge clk); #1;
    total++; if (bus.mem_read !== 1'b0) begin bad++; $display("FAIL reset_mem_read got=%b want=0", bus.mem_read); end
    total++; if (bus.mem_write !== 1'b0) begin bad++; $display("FAIL reset_mem_write got=%b want=0", bus.mem_write); end
    total++; if ({bus.i_mem_ready, bus.d_mem_ready} !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b%b want=00", bus.i_mem_ready, bus.d_mem_ready); end
    total++; if (bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin bad++; $display("FAIL reset_addr_wdata got=%h/%h want=0/0", bus.mem_addr, bus.mem_wdata); end
    @(negedge clk); #1;
    total++; if (i_txn_cnt !== 2'd0 || d_txn_cnt !== 2'd0) begin bad++; $display("FAIL reset_cnt got=%0d/%0d want=0/0", i_txn_cnt, d_txn_cnt); end
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL reset_proto_err got=%b want=0", proto_err); end
    $display("txn reset: outputs idle under reset");
  endtask

  task automatic test_i_only();
    int i_pulses = 0;
    int d_pulses = 0;
    do_reset();
    bus.i_mem_read = 1'b1;
    bus.i_mem_addr = 32'h40;
    for (int k = 0; k < 6; k++) begin
      if (k == 4) bus.i_mem_read = 1'b0;
      bus.mem_ready = (k == 3);
      bus.mem_rdata = (k == 3) ? 32'hA5A5 : 32'h0;
      #1;
      if (k == 0) begin
        total++; if (bus.mem_read !== 1'b0) begin bad++; $display("FAIL i_only_latency_t got=%b want=0", bus.mem_read); end
      end
      if (k == 1) begin
        total++; if (bus.mem_read !== 1'b1 || bus.mem_addr !== 32'h40) begin bad++; $display("FAIL i_only_t1 got=%b/%h want=1/40", bus.mem_read, bus.mem_addr); end
      end
      if (k == 3) begin
        total++; if (bus.i_mem_rdata !== 32'hA5A5) begin bad++; $display("FAIL i_only_rdata got=%h want=a5a5", bus.i_mem_rdata); end
      end
      if (bus.i_mem_ready === 1'b1) i_pulses++;
      if (bus.d_mem_ready !== 1'b0) d_pulses++;
      @(negedge clk);
    end
    total++; if (i_pulses != 1) begin bad++; $display("FAIL i_only_pulses got=%0d want=1", i_pulses); end
    total++; if (d_pulses != 0) begin bad++; $display("FAIL i_only_d_ready got=%0d want=0", d_pulses); end
    total++; if (i_txn_cnt !== 2'd1 || d_txn_cnt !== 2'd0) begin bad++; $display("FAIL i_only_cnt got=%0d/%0d want=1/0", i_txn_cnt, d_txn_cnt); end
    $display("txn i_only: read 0x40 data 0x%h", bus.i_mem_rdata);
  endtask

  task automatic test_simultaneous();
    do_reset();
    bus.i_mem_read = 1'b1; bus.i_mem_addr = 32'h10;
    bus.d_mem_read = 1'b1; bus.d_mem_addr = 32'h20;
    @(negedge clk);
    bus.mem_ready = 1'b1; #1;
    total++; if (bus.mem_addr !== 32'h20 || bus.mem_read !== 1'b1) begin bad++; $display("FAIL simul_d_first got=%h/%b want=20/1", bus.mem_addr, bus.mem_read); end
    total++; if (bus.d_mem_ready !== 1'b1 || bus.i_mem_ready !== 1'b0) begin bad++; $display("FAIL simul_d_ready got=d%b i%b want=d1 i0", bus.d_mem_ready, bus.i_mem_ready); end
    @(negedge clk);
    bus.mem_ready = 1'b0; bus.d_mem_read = 1'b0; #1;
    total++; if (bus.mem_read !== 1'b0 || bus.mem_addr !== '0) begin bad++; $display("FAIL simul_bubble got=%b/%h want=0/0", bus.mem_read, bus.mem_addr); end
    @(negedge clk);
    bus.mem_ready = 1'b1; #1;
    total++; if (bus.mem_addr !== 32'h10 || bus.mem_read !== 1'b1 || bus.i_mem_ready !== 1'b1) begin bad++; $display("FAIL simul_i_second got=%h/%b/%b want=10/1/1", bus.mem_addr, bus.mem_read, bus.i_mem_ready); end
    @(negedge clk);
    clear_inputs(); #1;
    total++; if (i_txn_cnt !== 2'd1 || d_txn_cnt !== 2'd1) begin bad++; $display("FAIL simul_cnt got=%0d/%0d want=1/1", i_txn_cnt, d_txn_cnt); end
    $display("txn simultaneous: D 0x20 then I 0x10");
  endtask

  task automatic test_write_then_read();
    do_reset();
    bus.d_mem_write = 1'b1; bus.d_mem_addr = 32'h80; bus.d_mem_wdata = 32'h1234;
    bus.i_mem_read = 1'b1; bus.i_mem_addr = 32'h44;
    @(negedge clk);
    bus.mem_ready = 1'b1; #1;
    total++; if ({bus.mem_write, bus.mem_read} !== 2'b10 || bus.mem_addr !== 32'h80 || bus.mem_wdata !== 32'h1234) begin bad++; $display("FAIL wr_write got=w%b r%b %h/%h want=w1 r0 80/1234", bus.mem_write, bus.mem_read, bus.mem_addr, bus.mem_wdata); end
    @(negedge clk);
    bus.mem_ready = 1'b0;
    bus.d_mem_write = 1'b0; bus.d_mem_read = 1'b1; bus.d_mem_addr = 32'h84; bus.d_mem_wdata = '0; #1;
    total++; if ({bus.mem_write, bus.mem_read} !== 2'b00 || bus.mem_wdata !== '0) begin bad++; $display("FAIL wr_bubble1 got=w%b r%b %h want=w0 r0 0", bus.mem_write, bus.mem_read, bus.mem_wdata); end
    @(negedge clk);
    bus.mem_ready = 1'b1; #1;
    total++; if (bus.mem_addr !== 32'h44 || {bus.mem_write, bus.mem_read} !== 2'b01 || bus.mem_wdata !== '0 || bus.i_mem_ready !== 1'b1) begin bad++; $display("FAIL wr_i_between got=%h w%b r%b %h rdy%b want=44 w0 r1 0 rdy1", bus.mem_addr, bus.mem_write, bus.mem_read, bus.mem_wdata, bus.i_mem_ready); end
    @(negedge clk);
    bus.mem_ready = 1'b0; bus.i_mem_read = 1'b0; #1;
    total++; if (bus.mem_read !== 1'b0) begin bad++; $display("FAIL wr_bubble2 got=%b want=0", bus.mem_read); end
    @(negedge clk);
    bus.mem_ready = 1'b1; #1;
    total++; if (bus.mem_addr !== 32'h84 || {bus.mem_write, bus.mem_read} !== 2'b01 || bus.d_mem_ready !== 1'b1) begin bad++; $display("FAIL wr_d_read got=%h w%b r%b rdy%b want=84 w0 r1 rdy1", bus.mem_addr, bus.mem_write, bus.mem_read, bus.d_mem_ready); end
    @(negedge clk);
    clear_inputs(); #1;
    total++; if (i_txn_cnt !== 2'd1 || d_txn_cnt !== 2'd2) begin bad++; $display("FAIL wr_cnt got=%0d/%0d want=1/2", i_txn_cnt, d_txn_cnt); end
    $display("txn write_then_read: W 0x80, R 0x44 (I), R 0x84 (D)");
  endtask

  task automatic test_abandon();
    do_reset();
    bus.i_mem_read = 1'b1; bus.i_mem_addr = 32'h60;
    @(negedge clk); #1;
    total++; if (bus.mem_read !== 1'b1) begin bad++; $display("FAIL abandon_grant got=%b want=1", bus.mem_read); end
    @(negedge clk);
    bus.i_mem_read = 1'b0; #1;
    total++; if (bus.mem_read !== 1'b0) begin bad++; $display("FAIL abandon_gated got=%b want=0", bus.mem_read); end
    @(negedge clk);
    bus.mem_ready = 1'b1; #1;
    total++; if (bus.i_mem_ready !== 1'b0) begin bad++; $display("FAIL abandon_late_ready got=%b want=0", bus.i_mem_ready); end
    @(negedge clk);
    clear_inputs(); #1;
    total++; if (i_txn_cnt !== 2'd0) begin bad++; $display("FAIL abandon_cnt got=%0d want=0", i_txn_cnt); end
    $display("txn abandon: I 0x60 dropped before ready");
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.d_mem_read = 1'b1; bus.d_mem_addr = 32'h30;
    @(negedge clk); #1;
    total++; if (bus.mem_read !== 1'b1) begin bad++; $display("FAIL rstmid_grant got=%b want=1", bus.mem_read); end
    proc_reset = 1'b1;
    @(negedge clk); #1;
    total++; if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin bad++; $display("FAIL rstmid_idle got=r%b w%b want=r0 w0", bus.mem_read, bus.mem_write); end
    bus.d_mem_read = 1'b0;
    @(negedge clk);
    proc_reset = 1'b0; bus.mem_ready = 1'b1; #1;
    total++; if (bus.d_mem_ready !== 1'b0 || bus.i_mem_ready !== 1'b0) begin bad++; $display("FAIL rstmid_ready got=d%b i%b want=d0 i0", bus.d_mem_ready, bus.i_mem_ready); end
    @(negedge clk);
    clear_inputs(); #1;
    total++; if (i_txn_cnt !== 2'd0 || d_txn_cnt !== 2'd0) begin bad++; $display("FAIL rstmid_cnt got=%0d/%0d want=0/0", i_txn_cnt, d_txn_cnt); end
    $display("txn reset_mid: D 0x30 aborted by reset");
  endtask

  task automatic test_proto_err();
    do_reset();
    bus.d_mem_read = 1'b1; bus.d_mem_write = 1'b1; bus.d_mem_addr = 32'h90; bus.d_mem_wdata = 32'h55;
    @(negedge clk);
    bus.mem_ready = 1'b1; #1;
    total++; if ({bus.mem_write, bus.mem_read} !== 2'b10 || bus.mem_wdata !== 32'h55) begin bad++; $display("FAIL proto_as_write got=w%b r%b %h want=w1 r0 55", bus.mem_write, bus.mem_read, bus.mem_wdata); end
    total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL proto_set got=%b want=1", proto_err); end
    @(negedge clk);
    clear_inputs();
    @(negedge clk); #1;
    total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL proto_sticky got=%b want=1", proto_err); end
    do_reset(); #1;
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL proto_cleared got=%b want=0", proto_err); end
    $display("txn proto_err: D read+write at 0x90 as write");
  endtask

  task automatic test_saturation();
    logic [CNT_W-1:0] exp_cnt;
    do_reset();
    for (int n = 1; n <= 5; n++) begin
      bus.i_mem_read = 1'b1; bus.i_mem_addr = 32'(n * 4);
      @(negedge clk);
      bus.mem_ready = 1'b1;
      @(negedge clk);
      clear_inputs(); #1;
      exp_cnt = (n >= 3) ? 2'd3 : 2'(n);
      total++; if (i_txn_cnt !== exp_cnt) begin bad++; $display("FAIL sat_cnt_%0d got=%0d want=%0d", n, i_txn_cnt, exp_cnt); end
      $display("txn saturation: I read %0d cnt=%0d", n, i_txn_cnt);
    end
    @(negedge clk); #1;
    total++; if (i_txn_cnt !== 2'd3) begin bad++; $display("FAIL sat_hold got=%0d want=3", i_txn_cnt); end
  endtask

  initial begin
    test_reset();
    test_i_only();
    test_simultaneous();
    test_write_then_read();
    test_abandon();
    test_reset_mid();
    test_proto_err();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
